wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  in  1 and in_ready  out  1, the handshake with the upstream memory stage (that stage's out_valid/out_ready).
REQ-004 SHALL have: result  in  32  ALU/mul/div result or load address; PC  in  32; mem_op  in  8  memory op one-hot; res_from_mem  in  1; gr_we  in  1; dest  in  5.
REQ-005 SHALL have: data_sram_rdata  in  32, load data, valid in the first cycle in_valid is high for an instruction.
REQ-006 SHALL have: rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32, the register-file write port.
REQ-007 SHALL have: debug_wb_pc  out  32; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32; debug_wb_valid  out  1; debug_wb_ready  in  1, the retire trace port.

Function
REQ-008 mem_op encoding SHALL be: [0] LB, [1] LH, [2] LW, [3] LBU, [4] LHU, [5] SB, [6] SH, [7] SW.
REQ-009 Retire SHALL occur when in_valid and in_ready are both high in a cycle; only a retire writes the register file.
REQ-010 On retire: rf_we = gr_we and dest != 0; rf_waddr = dest; rf_wdata = the load value if res_from_mem, else result. All three are combinational, with no added latency.
REQ-011 Load value SHALL be: byte select = result[1:0]; halfword select = result[1]. LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through.
REQ-012 A rdata hold register SHALL capture data_sram_rdata and set held=1 when in_valid=1, in_ready=0 and held=0.
REQ-013 While held=1, the load value SHALL use the held data, not live data_sram_rdata.
REQ-014 held SHALL clear on retire.
REQ-015 held=1 and a retire in the same cycle SHALL clear held, not recapture.
REQ-016 Store and non-memory ops SHALL ignore rdata.
REQ-017 Trace FIFO, depth 2: push one entry {PC, {4{rf_we}}, dest, rf_wdata} on every retire, including retires with rf_we=0.
REQ-018 Trace FIFO pop: when debug_wb_valid and debug_wb_ready are both high.
REQ-019 debug_wb_valid SHALL equal count != 0; debug_* outputs SHALL show the head entry.
REQ-020 in_ready SHALL be (count < 2) or debug_wb_ready.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; at count=2, push SHALL be accepted only if a pop occurs in that cycle.
REQ-022 FIFO read and write pointers SHALL each be 1 bit and wrap modulo 2.
REQ-023 in_valid=0 SHALL produce no retire, no push and rf_we=0.

Reset
REQ-024 While resetn=0, all state SHALL clear asynchronously: count=0, pointers=0, held=0, hold register=0, FIFO entries=0.
REQ-025 While resetn=0: in_ready=0, rf_we=0, debug_wb_valid=0, all debug_* data outputs=0.
REQ-026 After resetn rises, in_ready SHALL go to 1 in the same cycle (count=0).
REQ-027 Reset asserted mid-stall SHALL discard the held rdata and all FIFO contents; nothing from them is replayed.

Configuration
REQ-028 Macro WB_TRACE_FIFO_EN defined: the trace FIFO and backpressure SHALL be built per REQ-017..REQ-022.
REQ-029 Macro WB_TRACE_FIFO_EN undefined: no FIFO or hold register is built; debug_wb_ready is ignored.
REQ-030 With WB_TRACE_FIFO_EN undefined: in_ready = resetn.
REQ-031 With WB_TRACE_FIFO_EN undefined: debug_wb_valid equals the retire condition and debug_* outputs show the current retire combinationally.

Verification
REQ-032 LB, result=0x1000_0003, rdata=0x80AA_BBCC, dest=5, gr_we=1 -> rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FF80.
REQ-033 LHU, result=0x...2, rdata=0x8001_7FFF -> rf_wdata=0x0000_8001; LH, same address and rdata -> rf_wdata=0xFFFF_8001.
REQ-034 FIFO enabled, debug_wb_ready=0, three back-to-back retires -> first two accepted, in_ready=0 on the third. The third is a LW with rdata 0x1234_5678 then rdata changed to 0xDEAD_BEEF during the stall. Then debug_wb_ready=1 -> third retires with rf_wdata=0x1234_5678, and traces appear in program order.
REQ-035 gr_we=1, dest=0, result=0x55 -> rf_we=0; a trace entry is still pushed with debug_wb_rf_we=4'b0000.
REQ-036 resetn pulsed low while count=2 and held=1 -> debug_wb_valid=0 immediately, held=0, no trace entries emitted after release.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: load alignment/extension, register-file write port and retire trace.
// Define WB_TRACE_FIFO_EN to build the 2-entry trace FIFO, rdata hold register and backpressure.
module wb_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result,
    input  logic [31:0] PC,
    input  logic [7:0]  mem_op,
    input  logic        res_from_mem,
    input  logic        gr_we,
    input  logic [4:0]  dest,
    input  logic [31:0] data_sram_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        debug_wb_valid,
    input  logic        debug_wb_ready
);

    logic        retire;
    logic [31:0] rdata_sel;
    logic [31:0] load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store encodings (mem_op[7:5]) never select a load path.
    logic [2:0]  unused_store_ops;
    assign unused_store_ops = mem_op[7:5];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        ld_byte  = rdata_sel[7:0];
        load_val = rdata_sel;
        case (result[1:0])
            2'd1:    ld_byte = rdata_sel[15:8];
            2'd2:    ld_byte = rdata_sel[23:16];
            2'd3:    ld_byte = rdata_sel[31:24];
            default: ld_byte = rdata_sel[7:0];
        endcase
        ld_half = result[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        if (mem_op[0])      load_val = {{24{ld_byte[7]}}, ld_byte};
        else if (mem_op[1]) load_val = {{16{ld_half[15]}}, ld_half};
        else if (mem_op[3]) load_val = {24'h0, ld_byte};
        else if (mem_op[4]) load_val = {16'h0, ld_half};
    end

    assign retire   = in_valid & in_ready;
    assign rf_we    = retire & gr_we & (dest != 5'd0);
    assign rf_waddr = dest;
    assign rf_wdata = res_from_mem ? load_val : result;

`ifdef WB_TRACE_FIFO_EN

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_t;

    logic        held_q, held_d;
    logic [31:0] hold_q, hold_d;
    trace_t      fifo_q [2];
    trace_t      fifo_d [2];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  count_q, count_d;
    logic        push, pop;

    assign in_ready  = resetn & ((count_q < 2'd2) | debug_wb_ready);
    assign rdata_sel = held_q ? hold_q : data_sram_rdata;
    assign push      = retire;
    assign pop       = debug_wb_valid & debug_wb_ready;

    always_comb begin
        held_d  = held_q;
        hold_d  = hold_q;
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        // The load data is only valid in the first stalled cycle, so it is frozen until retire.
        if (retire) begin
            held_d = 1'b0;
        end else if (in_valid && !held_q) begin
            held_d = 1'b1;
            hold_d = data_sram_rdata;
        end

        if (push) begin
            fifo_d[wptr_q] = '{pc: PC, we: {4{rf_we}}, wnum: dest, wdata: rf_wdata};
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_q  <= 1'b0;
            hold_q  <= 32'h0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            // NOTE: the trace storage is reset too, so debug_* read as zero during and after reset.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            held_q  <= held_d;
            hold_q  <= hold_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

    assign debug_wb_valid    = (count_q != 2'd0);
    assign debug_wb_pc       = fifo_q[rptr_q].pc;
    assign debug_wb_rf_we    = fifo_q[rptr_q].we;
    assign debug_wb_rf_wnum  = fifo_q[rptr_q].wnum;
    assign debug_wb_rf_wdata = fifo_q[rptr_q].wdata;

`else

    // Without the FIFO the stage holds no state; the trace mirrors the current retire.
    logic [1:0] unused_trace_ctl;
    assign unused_trace_ctl = {clk, debug_wb_ready};

    assign in_ready          = resetn;
    assign rdata_sel         = data_sram_rdata;
    assign debug_wb_valid    = retire;
    assign debug_wb_pc       = retire ? PC : 32'h0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = retire ? dest : 5'd0;
    assign debug_wb_rf_wdata = retire ? rf_wdata : 32'h0;

`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table-driven load/ALU vectors plus stall, trace and reset sequences.
// Expectations follow WB_TRACE_FIFO_EN when it is defined for the build.
module tb_wb_stage;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic [31:0] pc;
    logic [7:0]  mem_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] data_sram_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        debug_wb_valid;
    logic        debug_wb_ready;

    int tests;
    int fails;

    localparam logic [7:0] OP_LB  = 8'h01;
    localparam logic [7:0] OP_LH  = 8'h02;
    localparam logic [7:0] OP_LW  = 8'h04;
    localparam logic [7:0] OP_LBU = 8'h08;
    localparam logic [7:0] OP_LHU = 8'h10;
    localparam logic [7:0] OP_SW  = 8'h80;

    typedef struct {
        logic [7:0]  mem_op;
        logic        rfm;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [12];

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .result            (result),
        .PC                (pc),
        .mem_op            (mem_op),
        .res_from_mem      (res_from_mem),
        .gr_we             (gr_we),
        .dest              (dest),
        .data_sram_rdata   (data_sram_rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .debug_wb_valid    (debug_wb_valid),
        .debug_wb_ready    (debug_wb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        mem_op          = v.mem_op;
        res_from_mem    = v.rfm;
        gr_we           = v.gr_we;
        dest            = v.dest;
        result          = v.result;
        data_sram_rdata = v.rdata;
        pc              = v.pc;
        in_valid        = 1'b1;
    endtask

    task automatic alu_op(input logic [31:0] p, input logic [31:0] r, input logic [4:0] d);
        vec_t v;
        v = '{8'h00, 1'b0, 1'b1, d, r, 32'h0, p, 1'b1, r};
        apply(v);
    endtask

    task automatic check_head(input string name, input logic [31:0] p, input logic [3:0] we,
                              input logic [4:0] d, input logic [31:0] wd);
        check({name, "_valid"}, 32'(debug_wb_valid), 32'd1);
        check({name, "_pc"},    debug_wb_pc, p);
        check({name, "_we"},    32'(debug_wb_rf_we), 32'(we));
        check({name, "_wnum"},  32'(debug_wb_rf_wnum), 32'(d));
        check({name, "_wdata"}, debug_wb_rf_wdata, wd);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{OP_LB,  1'b1, 1'b1, 5'd5,  32'h1000_0003, 32'h80AA_BBCC, 32'h1C00_0000, 1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{OP_LHU, 1'b1, 1'b1, 5'd6,  32'h2000_0002, 32'h8001_7FFF, 32'h1C00_0004, 1'b1, 32'h0000_8001};
        vecs[2]  = '{OP_LH,  1'b1, 1'b1, 5'd7,  32'h2000_0002, 32'h8001_7FFF, 32'h1C00_0008, 1'b1, 32'hFFFF_8001};
        vecs[3]  = '{OP_LW,  1'b1, 1'b1, 5'd8,  32'h0000_0004, 32'hCAFE_F00D, 32'h1C00_000C, 1'b1, 32'hCAFE_F00D};
        vecs[4]  = '{OP_LBU, 1'b1, 1'b1, 5'd9,  32'h0000_0001, 32'h1234_F0AB, 32'h1C00_0010, 1'b1, 32'h0000_00F0};
        vecs[5]  = '{OP_LB,  1'b1, 1'b1, 5'd10, 32'h0000_0002, 32'hAA71_BBCC, 32'h1C00_0014, 1'b1, 32'h0000_0071};
        vecs[6]  = '{OP_LH,  1'b1, 1'b1, 5'd11, 32'h0000_0000, 32'h1234_8765, 32'h1C00_0018, 1'b1, 32'hFFFF_8765};
        vecs[7]  = '{8'h00,  1'b0, 1'b1, 5'd12, 32'hDEAD_0001, 32'hFFFF_FFFF, 32'h1C00_001C, 1'b1, 32'hDEAD_0001};
        vecs[8]  = '{OP_SW,  1'b0, 1'b0, 5'd3,  32'h0000_0100, 32'h7777_7777, 32'h1C00_0020, 1'b0, 32'h0000_0100};
        vecs[9]  = '{8'h00,  1'b0, 1'b1, 5'd0,  32'h0000_0055, 32'h0000_0000, 32'h1C00_0024, 1'b0, 32'h0000_0055};
        vecs[10] = '{OP_LB,  1'b1, 1'b1, 5'd13, 32'h0000_0000, 32'h0000_007F, 32'h1C00_0028, 1'b1, 32'h0000_007F};
        vecs[11] = '{OP_LBU, 1'b1, 1'b1, 5'd31, 32'h0000_0003, 32'h80AA_BBCC, 32'h1C00_002C, 1'b1, 32'h0000_0080};

        // Reset state, with a would-be write presented on the inputs.
        resetn         = 1'b0;
        debug_wb_ready = 1'b1;
        apply(vecs[0]);
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_dbg_valid", 32'(debug_wb_valid), 32'd0);
        check("rst_dbg_pc", debug_wb_pc, 32'h0);
        check("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);
        in_valid = 1'b0;
        resetn   = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        // Table-driven retires with the trace sink always ready.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].dest));
            check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
`ifndef WB_TRACE_FIFO_EN
            check_head($sformatf("v%0d_trace", i), vecs[i].pc, {4{vecs[i].exp_we}},
                       vecs[i].dest, vecs[i].exp_wdata);
`endif
            step();
`ifdef WB_TRACE_FIFO_EN
            check_head($sformatf("v%0d_trace", i), vecs[i].pc, {4{vecs[i].exp_we}},
                       vecs[i].dest, vecs[i].exp_wdata);
`endif
        end

        // Idle input produces no write and, once drained, no trace.
        in_valid = 1'b0;
        gr_we    = 1'b1;
        dest     = 5'd4;
        #1;
        check("idle_rf_we", 32'(rf_we), 32'd0);
        step();
        check("idle_dbg_valid", 32'(debug_wb_valid), 32'd0);

`ifdef WB_TRACE_FIFO_EN
        // Backpressure: two retires fill the FIFO, the third LW stalls with its load data frozen.
        debug_wb_ready = 1'b0;
        alu_op(32'h100, 32'h11, 5'd1);
        step();
        alu_op(32'h104, 32'h22, 5'd2);
        #1;
        check("bp_second_ready", 32'(in_ready), 32'd1);
        step();
        apply('{OP_LW, 1'b1, 1'b1, 5'd3, 32'h8, 32'h1234_5678, 32'h108, 1'b1, 32'h1234_5678});
        #1;
        check("bp_third_ready", 32'(in_ready), 32'd0);
        check("bp_third_rf_we", 32'(rf_we), 32'd0);
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        step();
        check("bp_still_stalled", 32'(in_ready), 32'd0);
        check_head("bp_head_a", 32'h100, 4'hF, 5'd1, 32'h11);
        debug_wb_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_rf_we", 32'(rf_we), 32'd1);
        check("bp_held_wdata", rf_wdata, 32'h1234_5678);
        step();
        in_valid = 1'b0;
        check_head("bp_head_b", 32'h104, 4'hF, 5'd2, 32'h22);
        step();
        check_head("bp_head_c", 32'h108, 4'hF, 5'd3, 32'h1234_5678);
        step();
        check("bp_drained", 32'(debug_wb_valid), 32'd0);

        // After the stalled retire, a new load takes live data again.
        apply('{OP_LW, 1'b1, 1'b1, 5'd4, 32'hC, 32'h0BAD_F00D, 32'h10C, 1'b1, 32'h0BAD_F00D});
        #1;
        check("post_hold_live", rf_wdata, 32'h0BAD_F00D);
        step();
        in_valid = 1'b0;
        step();

        // Reset mid-stall with a full FIFO and held data.
        debug_wb_ready = 1'b0;
        alu_op(32'h200, 32'h33, 5'd1);
        step();
        alu_op(32'h204, 32'h44, 5'd2);
        step();
        apply('{OP_LW, 1'b1, 1'b1, 5'd3, 32'h0, 32'h1111_2222, 32'h208, 1'b1, 32'h1111_2222});
        step();
        data_sram_rdata = 32'h3333_4444;
        check("rs_full_valid", 32'(debug_wb_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("rs_dbg_valid", 32'(debug_wb_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd0);
        check("rs_dbg_pc", debug_wb_pc, 32'h0);
        #2;
        in_valid = 1'b0;
        resetn   = 1'b1;
        debug_wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rs_no_replay%0d", i), 32'(debug_wb_valid), 32'd0);
        end
        apply('{OP_LW, 1'b1, 1'b1, 5'd6, 32'h0, 32'h5555_6666, 32'h20C, 1'b1, 32'h5555_6666});
        #1;
        check("rs_held_cleared", rf_wdata, 32'h5555_6666);
        step();
        in_valid = 1'b0;
        check_head("rs_first_trace", 32'h20C, 4'hF, 5'd6, 32'h5555_6666);
        step();
`else
        // Without the FIFO the trace ignores debug_wb_ready and never stalls.
        debug_wb_ready = 1'b0;
        alu_op(32'h100, 32'h11, 5'd1);
        #1;
        check("nf_ready_ignored", 32'(in_ready), 32'd1);
        check_head("nf_trace", 32'h100, 4'hF, 5'd1, 32'h11);
        step();
        resetn = 1'b0;
        #1;
        check("rs_in_ready", 32'(in_ready), 32'd0);
        check("rs_dbg_valid", 32'(debug_wb_valid), 32'd0);
        check("rs_dbg_pc", debug_wb_pc, 32'h0);
        #2;
        in_valid = 1'b0;
        resetn   = 1'b1;
        step();
        check("rs_no_trace", 32'(debug_wb_valid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
